// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus multiply/divide unit opcodes and FSM states.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int MDU_STEPS = WORD_W;

  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Bundle of the multiply/divide unit request/result signals for the execute stage.
interface mdu_if
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = WORD_W
);
  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport mdu (
    input  start, op, a, b, flush,
    output busy, done, hi, lo, div_zero
  );

  modport tb (
    output start, op, a, b, flush,
    input  busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mdu_fixup.sv
// Combinational sign restoration of the unsigned multiply/divide result.
module mdu_fixup
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic               is_div,
  input  logic               sgn,
  input  logic               neg_a,
  input  logic               neg_b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  logic               neg_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    neg_res = sgn && (neg_a ^ neg_b);
    prod    = neg_res ? -acc : acc;
    quot    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // remainder follows the dividend's sign (truncating division)
    rem     = (sgn && neg_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi      = is_div ? rem  : prod[2*WIDTH-1:WIDTH];
    lo      = is_div ? quot : prod[WIDTH-1:0];
  end
endmodule

// File: rtl/mdu.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
module mdu
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mdu_state_t         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_div_reg, sgn_reg, neg_a_reg, neg_b_reg, dz_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic               busy_reg, done_reg, div_zero_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  logic               op_div, op_sgn, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, trial;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign div_zero = div_zero_reg;

  always_comb begin
    op_div = mdu_is_div(op);
    op_sgn = mdu_is_signed(op);
    b_zero = (b == '0);
    mag_a  = (op_sgn && a[WIDTH-1]) ? -a : a;
    mag_b  = (op_sgn && b[WIDTH-1]) ? -b : b;
  end

  // One step of shift-add multiply and of restoring divide over acc_reg.
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
    trial    = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};
    div_next = trial[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
  end

  mdu_fixup #(.WIDTH(WIDTH)) u_fixup (
    .is_div (is_div_reg),
    .sgn    (sgn_reg),
    .neg_a  (neg_a_reg),
    .neg_b  (neg_b_reg),
    .acc    (acc_reg),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      sgn_reg      <= 1'b0;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      dz_reg       <= 1'b0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !flush) begin
            state_reg  <= CALC;
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            is_div_reg <= op_div;
            sgn_reg    <= op_sgn;
            neg_a_reg  <= op_sgn && a[WIDTH-1];
            neg_b_reg  <= op_sgn && b[WIDTH-1];
            dz_reg     <= op_div && b_zero;
            opnd_reg   <= op_div ? mag_b : mag_a;
            // a divide by zero parks the raw dividend here for the HI result
            acc_reg    <= op_div ? {{WIDTH{1'b0}}, (b_zero ? a : mag_a)}
                                 : {{WIDTH{1'b0}}, mag_b};
          end
        end
        CALC: begin
          if (flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (dz_reg) begin
            state_reg <= FIX;
          end else begin
            acc_reg <= is_div_reg ? div_next : mul_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_STEP) state_reg <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            hi_reg    <= dz_reg ? acc_reg[WIDTH-1:0] : fix_hi;
            lo_reg    <= dz_reg ? '1 : fix_lo;
            if (is_div_reg) div_zero_reg <= dz_reg;
            state_reg <= DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus random ops against an arithmetic model.
module tb_mdu;
  import cpu_types_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic CLK;
  logic nRST;
  int   vectors = 0;
  int   miscompares = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  mdu_if #(.WIDTH(W)) mif();

  mdu #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .start    (mif.start),
    .op       (mif.op),
    .a        (mif.a),
    .b        (mif.b),
    .flush    (mif.flush),
    .busy     (mif.busy),
    .done     (mif.done),
    .hi       (mif.hi),
    .lo       (mif.lo),
    .div_zero (mif.div_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference results straight from integer arithmetic.
  function automatic void model(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (op)
      MDU_MULT:  begin p = sa * sb; {h, l} = p; end
      MDU_MULTU: begin u = {32'b0, a} * {32'b0, b}; {h, l} = u; end
      MDU_DIV: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = W'(sa / sb); h = W'(sa % sb); end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  task automatic rand_inputs();
    mif.a  = $urandom;
    mif.b  = $urandom;
    mif.op = mdu_op_t'(2'($urandom_range(0, 3)));
  endtask

  // Issue one op from a negedge; optionally poke start (ignored) or flush (ignored in DONE).
  task automatic run_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke_k, input int flush_k, input string tag);
    int lat, k;
    bit busy_ok, hold_ok;
    logic [W-1:0] h, l;
    lat = (mdu_is_div(op) && b == 0) ? 2 : LAT;
    mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b;
    @(negedge CLK);
    mif.start = 1'b0;
    rand_inputs();
    k = 0; busy_ok = 1; hold_ok = 1;
    while (mif.done !== 1'b1 && k < 100) begin
      if (mif.busy !== 1'b1) busy_ok = 0;
      if (mif.hi !== exp_hi || mif.lo !== exp_lo) hold_ok = 0;
      @(negedge CLK);
      k++;
      mif.start = (k == poke_k);
      mif.flush = (k == flush_k);
      if (k == poke_k) rand_inputs();
    end
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " busy_during"}, 64'(busy_ok), 64'd1);
    check({tag, " hilo_held"}, 64'(hold_ok), 64'd1);
    model(op, a, b, h, l);
    exp_hi = h; exp_lo = l;
    if (mdu_is_div(op)) exp_dz = (b == 0);
    check({tag, " hi"}, 64'(mif.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(mif.lo), 64'(exp_lo));
    check({tag, " div_zero"}, 64'(mif.div_zero), 64'(exp_dz));
    check({tag, " busy_at_done"}, 64'(mif.busy), 64'd0);
    @(negedge CLK);
    mif.start = 1'b0; mif.flush = 1'b0;
    check({tag, " done_single"}, 64'(mif.done), 64'd0);
    check({tag, " idle_after"}, 64'(mif.busy), 64'd0);
    $display("op %0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d [%s]",
             op, a, b, mif.hi, mif.lo, mif.div_zero, k, tag);
  endtask

  // Issue an op and flush it k cycles after accept; nothing may commit.
  task automatic abort_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int fk, input int poke_k, input string tag);
    bit seen_done;
    mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b;
    @(negedge CLK);
    mif.start = 1'b0;
    rand_inputs();
    for (int k = 1; k <= fk; k++) begin
      @(negedge CLK);
      mif.start = (k == poke_k);
      if (k == fk) mif.flush = 1'b1;
    end
    @(negedge CLK);
    mif.flush = 1'b0; mif.start = 1'b0;
    check({tag, " busy_after_flush"}, 64'(mif.busy), 64'd0);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (mif.done === 1'b1) seen_done = 1;
      @(negedge CLK);
    end
    check({tag, " no_done"}, 64'(seen_done), 64'd0);
    check({tag, " hi_kept"}, 64'(mif.hi), 64'(exp_hi));
    check({tag, " lo_kept"}, 64'(mif.lo), 64'(exp_lo));
    check({tag, " dz_kept"}, 64'(mif.div_zero), 64'(exp_dz));
    $display("abort op %0d at k=%0d: busy=%0d hi=%h lo=%h [%s]", op, fk, mif.busy, mif.hi, mif.lo, tag);
  endtask

  initial begin
    bit seen_done;
    logic [W-1:0] ra, rb;
    mdu_op_t rop;
    int sel;

    nRST = 1'b0;
    mif.start = 1'b0; mif.flush = 1'b0; mif.op = MDU_MULT; mif.a = '0; mif.b = '0;
    repeat (2) @(negedge CLK);
    check("reset busy", 64'(mif.busy), 64'd0);
    check("reset done", 64'(mif.done), 64'd0);
    check("reset hi", 64'(mif.hi), 64'd0);
    check("reset lo", 64'(mif.lo), 64'd0);
    check("reset dz", 64'(mif.div_zero), 64'd0);
    nRST = 1'b1;
    @(negedge CLK);

    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, "multu_max");
    check("multu_max hi const", 64'(mif.hi), 64'hFFFFFFFE);
    check("multu_max lo const", 64'(mif.lo), 64'h00000001);
    run_op(MDU_MULT, 32'hFFFFFFFD, 32'd7, -1, -1, "mult_neg3x7");
    run_op(MDU_MULT, 32'h80000000, 32'h80000000, -1, -1, "mult_minmin");
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, -1, -1, "div_m7_2");
    check("div_m7_2 lo const", 64'(mif.lo), 64'hFFFFFFFD);
    run_op(MDU_DIVU, 32'hFFFFFFF9, 32'd2, -1, -1, "divu_m7_2");
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, "div_ovf");
    check("div_ovf lo const", 64'(mif.lo), 64'h80000000);
    run_op(MDU_DIVU, 32'h1234, 32'd0, -1, -1, "divu_by0");
    check("divu_by0 dz const", 64'(mif.div_zero), 64'd1);
    run_op(MDU_MULT, 32'd5, 32'd6, -1, -1, "mult_keeps_dz");
    run_op(MDU_DIVU, 32'd10, 32'd3, -1, -1, "divu_10_3");
    run_op(MDU_DIV, 32'hFFFFFF00, 32'd0, -1, -1, "div_by0_signed");

    // start while busy, start and flush during DONE: all ignored
    run_op(MDU_MULT, 32'h12345678, 32'hFEDCBA98, 5, -1, "mult_poke_busy");
    run_op(MDU_DIV, 32'h7FFFFFFF, 32'hFFFFFFF0, LAT, LAT, "div_poke_done");

    abort_op(MDU_MULT, 32'hDEADBEEF, 32'h00C0FFEE, 10, 4, "flush_calc");
    abort_op(MDU_DIV, 32'h00000064, 32'h00000000, 1, -1, "flush_dz_calc");
    abort_op(MDU_DIVU, 32'hCAFEF00D, 32'h00000077, W, -1, "flush_fix");

    // flush in IDLE overrides start
    mif.start = 1'b1; mif.flush = 1'b1; mif.op = MDU_MULTU; mif.a = 32'd9; mif.b = 32'd9;
    @(negedge CLK);
    mif.start = 1'b0; mif.flush = 1'b0;
    check("idle_flush busy", 64'(mif.busy), 64'd0);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (mif.done === 1'b1) seen_done = 1;
      @(negedge CLK);
    end
    check("idle_flush no_done", 64'(seen_done), 64'd0);
    $display("idle flush+start: busy=%0d done_seen=%0d", mif.busy, seen_done);

    // synchronous reset mid-CALC, with start held during reset
    mif.start = 1'b1; mif.op = MDU_MULTU; mif.a = 32'h11111111; mif.b = 32'h22222222;
    @(negedge CLK);
    mif.start = 1'b0;
    repeat (15) @(negedge CLK);
    nRST = 1'b0; mif.start = 1'b1; mif.op = MDU_DIVU; mif.a = 32'd100; mif.b = 32'd7;
    @(negedge CLK);
    nRST = 1'b1; mif.start = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    check("midreset busy", 64'(mif.busy), 64'd0);
    check("midreset done", 64'(mif.done), 64'd0);
    check("midreset hi", 64'(mif.hi), 64'd0);
    check("midreset lo", 64'(mif.lo), 64'd0);
    check("midreset dz", 64'(mif.div_zero), 64'd0);
    @(negedge CLK);
    check("midreset start_ignored", 64'(mif.busy), 64'd0);
    $display("mid-CALC reset: busy=%0d hi=%h lo=%h", mif.busy, mif.hi, mif.lo);
    run_op(MDU_DIVU, 32'd100, 32'd7, -1, -1, "after_reset");

    for (int i = 0; i < 40; i++) begin
      rop = mdu_op_t'(2'($urandom_range(0, 3)));
      sel = $urandom_range(0, 9);
      ra = (sel == 0) ? 32'h80000000 : (sel < 3) ? 32'($urandom_range(0, 20)) : $urandom;
      sel = $urandom_range(0, 9);
      rb = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 15)) :
           (sel == 3) ? 32'hFFFFFFFF : $urandom;
      run_op(rop, ra, rb, -1, -1, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
